// File: rtl/seq_detect.sv
// -----------------------------------------------------------------------------
// seq_detect
//   Serial pattern detector. Shifts in qualified bits (a_valid=1) MSB first and
//   compares the newest W accepted bits against PATTERN. A match produces a
//   registered one-cycle pulse on y and bumps a saturating match counter.
//
// Parameters
//   W        pattern length (2..32)
//   PATTERN  W-bit target, PATTERN[W-1] oldest bit, PATTERN[0] newest bit
//   OVERLAP  1: history kept across matches, 0: history discarded on match
//   CNT_W    match counter width (1..32)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous clear of history, fill, counter and sat flag
//   a_valid      qualifies a
//   a            serial data bit
//   y            registered one-cycle match pulse
//   match_count  saturating match count
//   count_sat    sticky, set when match_count reaches all-ones
//   armed        history holds W valid bits
// -----------------------------------------------------------------------------
module seq_detect #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             a_valid,
   input  logic             a,
   output logic             y,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat,
   output logic             armed
);

   localparam int               FW        = $clog2(W + 1);
   localparam logic [FW-1:0]    FILL_FULL = FW'(W);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      FILLING = 1'b0,
      ARMED   = 1'b1
   } state_e;

   state_e           state_q;
   logic [W-1:0]     hist_q;
   logic [FW-1:0]    fill_q;
   logic             y_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sat_q;

   logic [W-1:0]     hist_d;
   logic [FW-1:0]    fill_d;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             match_s;

   // Candidate next history/fill if the current bit is accepted, and match test.
   always_comb begin
      hist_d    = {hist_q[W-2:0], a};
      fill_d    = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FW'(1));
      cnt_inc_s = cnt_q + CNT_W'(1);
      match_s   = (fill_d == FILL_FULL) && (hist_d == PATTERN);
   end

   // Detector FSM, history, fill counter, match counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILLING;
         hist_q  <= '0;
         fill_q  <= '0;
         y_q     <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else if (clear) begin
         // clear wins over a simultaneous valid bit; that bit is dropped
         state_q <= FILLING;
         hist_q  <= '0;
         fill_q  <= '0;
         y_q     <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         y_q <= 1'b0;
         if (a_valid) begin
            if (match_s) begin
               y_q <= 1'b1;
               // saturate: once all-ones the count never moves again
               if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_inc_s;
                  if (cnt_inc_s == CNT_MAX) begin
                     sat_q <= 1'b1;
                  end else begin
                     sat_q <= sat_q;
                  end
               end else begin
                  cnt_q <= cnt_q;
               end
               if (OVERLAP) begin
                  hist_q  <= hist_d;
                  fill_q  <= FILL_FULL;
                  state_q <= ARMED;
               end else begin
                  // non-overlapping: next match needs W fresh bits
                  hist_q  <= '0;
                  fill_q  <= '0;
                  state_q <= FILLING;
               end
            end else begin
               hist_q  <= hist_d;
               fill_q  <= fill_d;
               state_q <= (fill_d == FILL_FULL) ? ARMED : FILLING;
            end
         end else begin
            // gaps hold everything; the pulse still drops back to 0
            hist_q  <= hist_q;
            fill_q  <= fill_q;
            state_q <= state_q;
         end
      end
   end

   assign y           = y_q;
   assign match_count = cnt_q;
   assign count_sat   = sat_q;
   assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detect.sv
// -----------------------------------------------------------------------------
// tb_seq_detect
//   Three detector instances share one input stream:
//     d0: W=4, PATTERN=1011, OVERLAP=1, CNT_W=8
//     d1: W=4, PATTERN=1011, OVERLAP=0, CNT_W=8
//     d2: W=4, PATTERN=1011, OVERLAP=1, CNT_W=2
//   The reference keeps the full list of accepted bits plus, per instance, the
//   index where its usable history starts (moved by reset, clear and, for the
//   non-overlapping instance, by each match).
// -----------------------------------------------------------------------------
module tb_seq_detect;

   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       clear;
   logic       a_valid;
   logic       a;
   logic       y0, y1, y2;
   logic [7:0] mc0, mc1;
   logic [1:0] mc2;
   logic       s0, s1, s2;
   logic       ar0, ar1, ar2;

   seq_detect #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .a_valid(a_valid), .a(a),
      .y(y0), .match_count(mc0), .count_sat(s0), .armed(ar0));

   seq_detect #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .a_valid(a_valid), .a(a),
      .y(y1), .match_count(mc1), .count_sat(s1), .armed(ar1));

   seq_detect #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .a_valid(a_valid), .a(a),
      .y(y2), .match_count(mc2), .count_sat(s2), .armed(ar2));

   // reference model state
   logic [3:0] pat;
   bit         acc[$];
   int         start[3];
   int         cnt[3];
   bit         sat[3];
   bit         ey[3];
   int         cmax[3] = '{255, 255, 3};
   bit         ovl[3]  = '{1'b1, 1'b0, 1'b1};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit tail_match(input int k);
      int n;
      n = acc.size();
      if (n - start[k] < W) return 1'b0;
      for (int i = 0; i < W; i++) begin
         if (acc[n - W + i] != pat[W-1-i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit exp_armed(input int k);
      return (acc.size() - start[k]) >= W;
   endfunction

   task automatic model_discard();
      for (int k = 0; k < 3; k++) begin
         start[k] = acc.size();
         cnt[k]   = 0;
         sat[k]   = 1'b0;
         ey[k]    = 1'b0;
      end
   endtask

   task automatic model_accept(input bit b);
      acc.push_back(b);
      for (int k = 0; k < 3; k++) begin
         ey[k] = 1'b0;
         if (tail_match(k)) begin
            ey[k] = 1'b1;
            if (cnt[k] < cmax[k]) cnt[k]++;
            if (cnt[k] == cmax[k]) sat[k] = 1'b1;
            if (!ovl[k]) start[k] = acc.size();
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".d0.y"},   32'(y0),  32'(ey[0]));
      chk({tag, ".d0.cnt"}, 32'(mc0), 32'(cnt[0]));
      chk({tag, ".d0.sat"}, 32'(s0),  32'(sat[0]));
      chk({tag, ".d0.arm"}, 32'(ar0), 32'(exp_armed(0)));
      chk({tag, ".d1.y"},   32'(y1),  32'(ey[1]));
      chk({tag, ".d1.cnt"}, 32'(mc1), 32'(cnt[1]));
      chk({tag, ".d1.sat"}, 32'(s1),  32'(sat[1]));
      chk({tag, ".d1.arm"}, 32'(ar1), 32'(exp_armed(1)));
      chk({tag, ".d2.y"},   32'(y2),  32'(ey[2]));
      chk({tag, ".d2.cnt"}, 32'(mc2), 32'(cnt[2]));
      chk({tag, ".d2.sat"}, 32'(s2),  32'(sat[2]));
      chk({tag, ".d2.arm"}, 32'(ar2), 32'(exp_armed(2)));
   endtask

   // drive one cycle, advance the model on the edge, check 1 time unit later
   task automatic step(input string tag, input logic v, input logic b, input logic c);
      a_valid = v;
      a       = b;
      clear   = c;
      @(posedge clk);
      for (int k = 0; k < 3; k++) ey[k] = 1'b0;
      if (c) model_discard();
      else if (v) model_accept(b);
      #1;
      check_all(tag);
   endtask

   task automatic send_bits(input string tag, input string s);
      for (int i = 0; i < s.len(); i++) begin
         step(tag, 1'b1, s.getc(i) == "1", 1'b0);
      end
   endtask

   initial begin
      pat     = 4'b1011;
      rst_n   = 1'b0;
      clear   = 1'b0;
      a_valid = 1'b0;
      a       = 1'b0;
      model_discard();

      // reset state, before any clock edge
      #3;
      check_all("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // overlapping vs non-overlapping on 1011011
      send_bits("ovl", "1011011");
      chk("ovl.d0.cnt2", 32'(mc0), 32'd2);
      chk("ovl.d1.cnt1", 32'(mc1), 32'd1);
      chk("ovl.d1.arm0", 32'(ar1), 32'd0);

      // gaps of 3 invalid cycles between the bits of 1011
      step("clr1", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step("gap", 1'b1, pat[3-i], 1'b0);
         if (i < 3) begin
            for (int j = 0; j < 3; j++) step("gap.idle", 1'b0, 1'($urandom_range(1)), 1'b0);
         end
      end
      step("gap.after", 1'b0, 1'b1, 1'b0);

      // saturating counter: five overlapping matches
      step("clr2", 1'b1, 1'b1, 1'b1);
      send_bits("sat", "1011011011011011");
      chk("sat.d2.cnt3", 32'(mc2), 32'd3);
      chk("sat.d2.sat1", 32'(s2),  32'd1);
      chk("sat.d0.cnt5", 32'(mc0), 32'd5);

      // clear coincides with the last pattern bit
      step("clr3", 1'b0, 1'b0, 1'b1);
      send_bits("clrhit", "101");
      step("clrhit.last", 1'b1, 1'b1, 1'b1);
      chk("clrhit.y0", 32'(y0), 32'd0);
      send_bits("clrhit.again", "1011");
      chk("clrhit.cnt1", 32'(mc0), 32'd1);

      // async reset in the middle of 101
      send_bits("rst.pre", "101");
      #2;
      rst_n = 1'b0;
      #1;
      model_discard();
      check_all("rst.async");
      @(posedge clk);
      #1;
      check_all("rst.held");
      rst_n = 1'b1;
      send_bits("rst.post", "11011");
      chk("rst.post.cnt1", 32'(mc0), 32'd1);

      // randomized stream with occasional clears
      for (int n = 0; n < 400; n++) begin
         step("rand", $urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(39) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_detect.md
Name: seq_detect

Overview:
- Parametrised serial pattern detector; successor to the team's fixed two-state input-tracking FSM.
- Takes a qualified serial bit stream and compares the most recent W accepted bits, MSB first, against a configurable PATTERN.
- Emits a one-cycle match pulse and keeps a saturating match count.
- Used as a front-end event detector ahead of control FSMs.

Parameters:
- W, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, W-bit target; PATTERN[W-1] is the oldest bit, PATTERN[0] the newest.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history is discarded after each match.
- CNT_W, 8, match counter width; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of history, fill count, counter and saturation flag.
- a_valid  input  1  a is sampled only on cycles where a_valid=1.
- a  input  1  serial data bit.
- y  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  saturating count of matches.
- count_sat  output  1  sticky flag; set when match_count reaches all-ones.
- armed  output  1  history holds W valid bits (fill==W).

Behaviour:
- Reset: rst_n=0 clears hist, fill, y, match_count, count_sat and armed to 0 immediately, independent of clk. Release is synchronous to the next clk edge. A reset mid-stream discards all partial history.
- State:
  - hist[W-1:0] shift register.
  - fill counter 0..W, width clog2(W+1).
  - FSM with FILLING (fill<W) and ARMED (fill==W). armed = (state==ARMED).
- Accept (a_valid=1, clear=0):
  - hist_n = {hist[W-2:0], a}.
  - fill_n = min(fill+1, W).
  - match = (fill_n==W) && (hist_n==PATTERN).
- Output latency: y=1 for exactly the one cycle following the edge that accepted the final pattern bit. Otherwise y=0.
- a_valid=0: hist, fill and counter hold; y=0. Gaps of any length do not break a sequence.
- On match with OVERLAP=1: hist=hist_n, fill stays W, state stays ARMED.
- On match with OVERLAP=0: hist=0, fill=0, state goes to FILLING. The next match needs W fresh accepted bits.
- Counter:
  - On match, if match_count != all-ones, increment by 1.
  - If the increment result is all-ones, set count_sat on the same edge.
  - Once at all-ones, further matches still pulse y; the count holds and count_sat stays 1.
  - No wrap-around, ever.
- clear=1: on the next edge hist=0, fill=0, state=FILLING, match_count=0, count_sat=0, y=0.
  - clear has priority over a simultaneous a_valid; that bit is discarded.
  - clear does not affect a y pulse already being driven in the current cycle.
- FILLING→ARMED when fill_n==W. ARMED→FILLING only on clear, reset, or a match with OVERLAP=0.
- No combinational path from any input to any output.

Test Plan:
- OVERLAP=1, PATTERN=1011; a_valid=1 every cycle, a=1,0,1,1,0,1,1 -> y pulses in the cycles after bit 4 and bit 7; match_count=2; armed=1 from after bit 4 onward.
- OVERLAP=0, same stream -> y pulses only after bit 4; match_count=1; armed=0 for cycles after bit 4, and fill=3 at end.
- Stream 1,0,1,1 with a_valid=0 gaps of 3 cycles between bits -> exactly one y pulse, one cycle after the 4th valid bit; no pulses during the gaps.
- CNT_W=2, OVERLAP=1; stream 1011011011011011 (5 matches) -> five y pulses; match_count goes 1,2,3,3,3; count_sat rises on the 3rd match and stays high.
- clear asserted in the same cycle as the 4th bit of 1011 -> no y pulse; hist=0, fill=0, match_count=0. A following 1011 yields one pulse.
- rst_n pulsed low mid-way through 101 -> outputs go to 0 asynchronously. After release, 1,1,0,1,1 yields one pulse, after the final bit only.
